// File: rtl/fir_tap_sequencer_if.sv
// Sample/coefficient/result bundle between the FIR sequencer and its environment.
interface fir_tap_sequencer_if #(
   parameter int N_TAPS  = 4,
   parameter int BW_in   = 6,
   parameter int BW_coef = 6,
   parameter int BW_out  = 8
);
   localparam int AW = $clog2(N_TAPS);

   logic                      in_valid;
   logic                      in_ready;
   logic signed [BW_in-1:0]   x_in;
   logic                      coef_we;
   logic [AW-1:0]             coef_addr;
   logic signed [BW_coef-1:0] coef_data;
   logic                      out_valid;
   logic signed [BW_out-1:0]  y_out;
   logic                      busy;

   modport master (
      output in_valid, x_in, coef_we, coef_addr, coef_data,
      input  in_ready, out_valid, y_out, busy
   );

   modport slave (
      input  in_valid, x_in, coef_we, coef_addr, coef_data,
      output in_ready, out_valid, y_out, busy
   );
endinterface

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR: one shared signed multiplier walks the taps, then the
// accumulator is floor-shifted and saturated into the result byte.
//
// state | meaning
// IDLE  | waiting for a sample; coefficient writes accepted
// MAC   | one tap per cycle: acc += d[tap] * c[tap]
// OUT   | result scaled/saturated into y_out on the exit edge
module fir_tap_sequencer #(
   parameter int N_TAPS  = 4,
   parameter int BW_in   = 6,
   parameter int BW_coef = 6,
   parameter int BW_out  = 8,
   parameter int SHIFT   = 4
) (
   input logic               clk,
   input logic               rst,
   fir_tap_sequencer_if.slave bus
);
   localparam int TW    = $clog2(N_TAPS);
   localparam int PW    = BW_in + BW_coef;
   localparam int ACC_W = PW + TW;
   localparam logic [TW-1:0] LAST_TAP = TW'(N_TAPS - 1);
   localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((2 ** (BW_out - 1)) - 1);
   localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-(2 ** (BW_out - 1)));

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t                    state_q, state_d;
   logic [TW-1:0]             tap_q;
   logic signed [ACC_W-1:0]   acc_q;
   logic signed [BW_in-1:0]   d_q [N_TAPS];
   logic signed [BW_coef-1:0] c_q [N_TAPS];
   logic                      ready_q;
   logic                      out_valid_q;
   logic signed [BW_out-1:0]  y_q;

   logic                      accept, mac_en, out_en;
   logic signed [PW-1:0]      d_ext, c_ext, prod;
   logic signed [ACC_W-1:0]   prod_ext, shifted;
   logic signed [BW_out-1:0]  y_sat;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next state and per-cycle control strobes.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      mac_en  = 1'b0;
      out_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.in_valid && ready_q) begin
               accept  = 1'b1;
               state_d = MAC;
            end
         end
         MAC: begin
            mac_en = 1'b1;
            if (tap_q == LAST_TAP) state_d = OUT;
         end
         OUT: begin
            out_en  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Shared multiplier: operands sign-extended to full product width first.
   always_comb begin
      d_ext    = PW'(d_q[tap_q]);
      c_ext    = PW'(c_q[tap_q]);
      prod     = d_ext * c_ext;
      prod_ext = ACC_W'(prod);
   end

   // Floor scaling (arithmetic shift) followed by clamp to the output range.
   always_comb begin
      shifted = acc_q >>> SHIFT;
      if (shifted > Y_MAX)      y_sat = Y_MAX[BW_out-1:0];
      else if (shifted < Y_MIN) y_sat = Y_MIN[BW_out-1:0];
      else                      y_sat = shifted[BW_out-1:0];
   end

   // in_ready stays low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ready_q <= 1'b0;
      else      ready_q <= 1'b1;
   end

   // Delay line shifts on accept; coefficients written only while idle, so a
   // write on the accept edge is seen by that sample's pass.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < N_TAPS; k++) begin
            d_q[k] <= '0;
            c_q[k] <= '0;
         end
      end else begin
         if (accept) begin
            for (int k = N_TAPS - 1; k >= 1; k--) d_q[k] <= d_q[k-1];
            d_q[0] <= bus.x_in;
         end
         if (bus.coef_we && state_q == IDLE) c_q[bus.coef_addr] <= bus.coef_data;
      end
   end

   // Tap counter and accumulator; tap wraps naturally since N_TAPS is 2^n.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tap_q <= '0;
         acc_q <= '0;
      end else if (accept) begin
         tap_q <= '0;
         acc_q <= '0;
      end else if (mac_en) begin
         tap_q <= tap_q + TW'(1);
         acc_q <= acc_q + prod_ext;
      end
   end

   // Result register and its one-cycle valid pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         y_q         <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= out_en;
         if (out_en) y_q <= y_sat;
      end
   end

   assign bus.in_ready  = ready_q && (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.y_out     = y_q;
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: directed filter cases plus random traffic,
// all checked against a sum-of-products model of the filter.
module tb_fir_tap_sequencer;
   localparam int N  = 4;
   localparam int SH = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fir_tap_sequencer_if bus ();
   fir_tap_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

   int checks   = 0;
   int failures = 0;
   bit started  = 1'b0;

   // Model state: coefficients, sample history (index 0 newest), and the edge
   // count of the latest accepted sample.
   int coef_m [N];
   int hist_m [N];
   bit have_acc;
   int ec, last_e;
   bit ready_m;
   int y_pend, y_hold;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int floor_div(input int s);
      int q;
      q = s / (2 ** SH);
      if (s < 0 && q * (2 ** SH) != s) q = q - 1;
      return q;
   endfunction

   function automatic int clamp(input int v);
      if (v > 127)  return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   function automatic int filter_out();
      int s;
      s = 0;
      for (int k = 0; k < N; k++) s += hist_m[k] * coef_m[k];
      return clamp(floor_div(s));
   endfunction

   // Reference model: evaluated at each rising edge from the inputs alone.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < N; k++) begin
            coef_m[k] = 0;
            hist_m[k] = 0;
         end
         have_acc = 1'b0;
         ec = 0; last_e = 0;
         ready_m = 1'b0;
         y_pend = 0; y_hold = 0;
      end else begin
         bit busy_b, rdy_b;
         busy_b = have_acc && ((ec - last_e) <= N);
         rdy_b  = ready_m && !busy_b;
         ec++;
         ready_m = 1'b1;
         if (!busy_b && bus.coef_we === 1'b1) coef_m[int'(bus.coef_addr)] = int'(bus.coef_data);
         if (rdy_b && bus.in_valid === 1'b1) begin
            for (int k = N - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
            hist_m[0] = int'(bus.x_in);
            y_pend   = filter_out();
            have_acc = 1'b1;
            last_e   = ec;
         end
         if (have_acc && (ec - last_e) == N + 1) y_hold = y_pend;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (started) begin
         if (!rst) begin
            chk("rst_y_out", int'(bus.y_out), 0);
            chk("rst_out_valid", int'(bus.out_valid), 0);
            chk("rst_in_ready", int'(bus.in_ready), 0);
            chk("rst_busy", int'(bus.busy), 0);
         end else begin
            bit eb;
            eb = have_acc && ((ec - last_e) <= N);
            chk("busy", int'(bus.busy), int'(eb));
            chk("in_ready", int'(bus.in_ready), int'(ready_m && !eb));
            chk("out_valid", int'(bus.out_valid), int'(have_acc && (ec - last_e) == N + 1));
            chk("y_out", int'(bus.y_out), y_hold);
         end
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 30 && bus.in_ready !== 1'b1; i++) @(negedge clk);
      if (bus.in_ready !== 1'b1) chk("timeout_idle", int'(bus.in_ready), 1);
   endtask

   task automatic wait_out(output int y, output int lat);
      lat = 1;
      for (int i = 0; i < 20 && bus.out_valid !== 1'b1; i++) begin
         @(negedge clk);
         lat++;
      end
      if (bus.out_valid !== 1'b1) chk("timeout_out", int'(bus.out_valid), 1);
      y = int'(bus.y_out);
   endtask

   task automatic set_coef(input int a, input int v);
      wait_idle();
      bus.coef_we   = 1'b1;
      bus.coef_addr = 2'(a);
      bus.coef_data = 6'(v);
      @(negedge clk);
      bus.coef_we = 1'b0;
   endtask

   task automatic set_all(input int c0, input int c1, input int c2, input int c3);
      set_coef(0, c0); set_coef(1, c1); set_coef(2, c2); set_coef(3, c3);
   endtask

   task automatic send(input int x, input bit wr, input int wa, input int wv,
                       output int y, output int lat);
      wait_idle();
      bus.in_valid = 1'b1;
      bus.x_in     = 6'(x);
      if (wr) begin
         bus.coef_we   = 1'b1;
         bus.coef_addr = 2'(wa);
         bus.coef_data = 6'(wv);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.coef_we  = 1'b0;
      wait_out(y, lat);
   endtask

   task automatic send_chk(input string nm, input int x, input int exp);
      int y, lat;
      send(x, 1'b0, 0, 0, y, lat);
      chk(nm, y, exp);
   endtask

   task automatic flush();
      int y, lat;
      for (int i = 0; i < N; i++) send(0, 1'b0, 0, 0, y, lat);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int y, lat;
      bus.in_valid = 1'b0; bus.x_in = '0;
      bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      started = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      #1 chk("ready_before_first_edge", int'(bus.in_ready), 0);
      @(negedge clk);
      chk("ready_after_first_edge", int'(bus.in_ready), 1);

      // Identity filter and accept-to-result latency.
      set_all(16, 0, 0, 0);
      send(5, 1'b0, 0, 0, y, lat);
      chk("identity_5", y, 5);
      chk("latency", lat, 6);
      send_chk("identity_m7", -7, -7);

      // Impulse response.
      set_all(16, -16, 8, 4);
      flush();
      send_chk("impulse_0", 16, 16);
      send_chk("impulse_1", 0, -16);
      send_chk("impulse_2", 0, 8);
      send_chk("impulse_3", 0, 4);

      // Saturation both ways.
      set_all(31, 31, 31, 31);
      for (int i = 0; i < 3; i++) send(31, 1'b0, 0, 0, y, lat);
      send_chk("sat_pos", 31, 127);
      for (int i = 0; i < 3; i++) send(-32, 1'b0, 0, 0, y, lat);
      send_chk("sat_neg", -32, -128);

      // Floor rounding.
      set_all(1, 0, 0, 0);
      flush();
      send_chk("floor_m1", -1, -1);
      send_chk("floor_p1", 1, 0);

      // Writes and samples offered mid-pass are ignored.
      set_all(16, 0, 0, 0);
      flush();
      wait_idle();
      bus.in_valid = 1'b1; bus.x_in = 6'(3);
      @(negedge clk);
      bus.x_in = 6'(9);
      bus.coef_we = 1'b1; bus.coef_addr = 2'(0); bus.coef_data = 6'(1);
      repeat (3) @(negedge clk);
      bus.in_valid = 1'b0; bus.coef_we = 1'b0;
      wait_out(y, lat);
      chk("coef_mid_pass_ignored", y, 3);
      send_chk("coef_persists", 2, 2);
      set_all(0, 0, 16, 0);
      send_chk("busy_sample_dropped", 0, 3);

      // Coefficient write on the accept edge applies to that pass.
      send(6, 1'b1, 0, 16, y, lat);
      chk("coef_same_edge", y, 8);

      // Reset mid-pass.
      wait_idle();
      bus.in_valid = 1'b1; bus.x_in = 6'(5);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      chk("midrst_y_out", int'(bus.y_out), 0);
      chk("midrst_out_valid", int'(bus.out_valid), 0);
      chk("midrst_in_ready", int'(bus.in_ready), 0);
      chk("midrst_busy", int'(bus.busy), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1 chk("rerelease_ready_low", int'(bus.in_ready), 0);
      @(negedge clk);
      chk("rerelease_ready_high", int'(bus.in_ready), 1);
      send_chk("coefs_cleared", 7, 0);

      // Random traffic, including collisions and back-to-back offers.
      repeat (600) begin
         @(negedge clk);
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.x_in      = 6'($urandom_range(0, 63));
         bus.coef_we   = ($urandom_range(0, 3) == 0);
         bus.coef_addr = 2'($urandom_range(0, 3));
         bus.coef_data = 6'($urandom_range(0, 63));
      end
      @(negedge clk);
      bus.in_valid = 1'b0; bus.coef_we = 1'b0;
      repeat (10) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
